// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes, FSM states
// and the natural-alignment test.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_SPLIT  = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw little-endian load bytes to 32 bits by access size.
module load_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request at a time, aligned accesses in a
// single memory cycle, misaligned ones split into byte accesses.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word requests instead of splitting them.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_length,
    output logic              mem_sign,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wr_q,    wr_d;
    logic [1:0]        size_q,  size_d;
    logic              uns_q,   uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q,   idx_d;
    logic              err_q,   err_d;
    logic [31:0]       raw_q,   raw_d;

    logic [1:0]        split_last;
    logic [31:0]       ext_data;

    load_extend u_load_extend (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .raw_i      (raw_q),
        .data_o     (ext_data)
    );

    assign split_last = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
    assign req_ready  = rst_n && (state_q == ST_IDLE);

    always_comb begin
        // NOTE: every output and next-state value gets a default here so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        err_d      = err_q;
        raw_d      = raw_q;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_length = '0;
        mem_sign   = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wr_d    = req_wr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                    raw_d   = '0;
                    err_d   = 1'b0;
                    if (req_size == SZ_ILL) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!is_aligned(req_size, req_addr[1:0])) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        err_d   = 1'b1;
                        state_d = ST_RESP;
`else
                        state_d = ST_SPLIT;
`endif
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                mem_en     = 1'b1;
                mem_wr     = wr_q;
                mem_addr   = addr_q;
                mem_length = size_q;
                mem_sign   = ~uns_q;
                mem_wdata  = wdata_q;
                if (!wr_q) raw_d = mem_rdata;
                state_d    = ST_RESP;
            end

`ifndef LSU_MISALIGN_TRAP_EN
            ST_SPLIT: begin
                // Byte lanes walk upward from the base address, wrapping at the top.
                mem_en     = 1'b1;
                mem_wr     = wr_q;
                mem_addr   = addr_q + ADDR_W'(idx_q);
                mem_wdata  = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
                if (!wr_q) raw_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
                if (idx_q == split_last) begin
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
`endif

            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (wr_q || err_q) ? 32'd0 : ext_data;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge next-state value.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            raw_q   <= raw_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed-vector bench for lsu_mem_master against a byte-addressed memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_wr, mem_sign;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_length;
    logic [31:0] mem_rdata = 32'd0;

    int total = 0;
    int bad   = 0;
    int idle_viol = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  len;
        logic        sign;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nacc;
        logic [31:0] exp_mem;
    } vec_t;

    logic [7:0] mem [logic [31:0]];
    acc_t       acc_log[$];

    lsu_mem_master #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_length   (mem_length),
        .mem_sign     (mem_sign),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd8(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd32(input logic [31:0] a);
        return {rd8(a + 32'd3), rd8(a + 32'd2), rd8(a + 32'd1), rd8(a)};
    endfunction

    task automatic poke32(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raw little-endian memory: the DUT is responsible for any extension.
    always @(negedge clk) mem_rdata = rd32(mem_addr);

    always @(negedge clk) begin
        if (mem_en) acc_log.push_back({mem_addr, mem_wr, mem_length, mem_sign, mem_wdata});
        if (mon_on && !mem_en && ({mem_wr, mem_addr, mem_length, mem_sign, mem_wdata} != '0))
            idle_viol++;
    end

    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            case (mem_length)
                2'b00:   mem[mem_addr] = mem_wdata[7:0];
                2'b01:   for (int i = 0; i < 2; i++) mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                default: for (int i = 0; i < 4; i++) mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
            endcase
        end
    end

    task automatic run_vec(input int id, input vec_t v);
        logic [1:0]  lo;
        logic        split;
        logic [31:0] got_rdata;
        logic        got_err;
        int          lat;
        acc_t        exp_acc;
        lo    = v.addr[1:0];
        split = (v.size == 2'b01 && lo[0]) || (v.size == 2'b10 && lo != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        if (split) begin
            v.exp_err = 1'b1; v.exp_rdata = '0; v.exp_lat = 1; v.exp_nacc = 0; v.exp_mem = v.init;
        end
`endif
        poke32(v.addr, v.init);
        @(negedge clk);
        acc_log.delete();
        req_valid = 1'b1; req_addr = v.addr; req_wr = v.wr; req_size = v.size;
        req_unsigned = v.uns; req_wdata = v.wdata;
        check($sformatf("v%0d_ready", id), req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = ~v.addr; req_wr = ~v.wr; req_size = 2'b10;
        req_unsigned = ~v.uns; req_wdata = ~v.wdata;
        lat = 0; got_rdata = 'x; got_err = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n; got_rdata = rsp_rdata; got_err = rsp_err;
                break;
            end
        end
        check($sformatf("v%0d_latency", id), lat, v.exp_lat);
        check($sformatf("v%0d_rdata", id), got_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", id), got_err, v.exp_err);
        check($sformatf("v%0d_naccess", id), acc_log.size(), v.exp_nacc);
        for (int i = 0; i < acc_log.size() && i < v.exp_nacc; i++) begin
            if (split)
                exp_acc = {v.addr + 32'(i), v.wr, 2'b00, 1'b0, {24'b0, v.wdata[8*i +: 8]}};
            else
                exp_acc = {v.addr, v.wr, v.size, ~v.uns, v.wdata};
            check($sformatf("v%0d_acc%0d", id, i), acc_log[i], exp_acc);
        end
        check($sformatf("v%0d_mem", id), rd32(v.addr), v.exp_mem);
        @(negedge clk);
        check($sformatf("v%0d_idle_after", id), {rsp_valid, req_ready}, 2'b01);
    endtask

    vec_t vecs[16];
    int   accepts[$];
    int   rsp_cnt;

    initial begin
        //           addr          wr    sz     uns   wdata         init          rdata         err  lat n  mem
        vecs[0]  = '{32'h10,       1'b0, 2'b10, 1'b0, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 2, 1, 32'h12345678};
        vecs[1]  = '{32'h21,       1'b0, 2'b01, 1'b0, 32'h0,        32'h0000FF80, 32'hFFFFFF80, 1'b0, 3, 2, 32'h0000FF80};
        vecs[2]  = '{32'h21,       1'b0, 2'b01, 1'b1, 32'h0,        32'h0000FF80, 32'h0000FF80, 1'b0, 3, 2, 32'h0000FF80};
        vecs[3]  = '{32'h40,       1'b0, 2'b00, 1'b0, 32'h0,        32'h000000F0, 32'hFFFFFFF0, 1'b0, 2, 1, 32'h000000F0};
        vecs[4]  = '{32'h41,       1'b0, 2'b00, 1'b1, 32'h0,        32'h000000F0, 32'h000000F0, 1'b0, 2, 1, 32'h000000F0};
        vecs[5]  = '{32'h50,       1'b0, 2'b01, 1'b0, 32'h0,        32'hDEAD8001, 32'hFFFF8001, 1'b0, 2, 1, 32'hDEAD8001};
        vecs[6]  = '{32'h60,       1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[7]  = '{32'h33,       1'b1, 2'b10, 1'b0, 32'hAABBCCDD, 32'h0,        32'h0,        1'b0, 5, 4, 32'hAABBCCDD};
        vecs[8]  = '{32'h70,       1'b1, 2'b10, 1'b0, 32'h11223344, 32'h0,        32'h0,        1'b0, 2, 1, 32'h11223344};
        vecs[9]  = '{32'h81,       1'b1, 2'b00, 1'b1, 32'h12345699, 32'hA5A5A5A5, 32'h0,        1'b0, 2, 1, 32'hA5A5A599};
        vecs[10] = '{32'h103,      1'b0, 2'b10, 1'b0, 32'h0,        32'h87654321, 32'h87654321, 1'b0, 5, 4, 32'h87654321};
        vecs[11] = '{32'h91,       1'b1, 2'b01, 1'b0, 32'h1234BEEF, 32'h0,        32'h0,        1'b0, 3, 2, 32'h0000BEEF};
        vecs[12] = '{32'hFFFFFFFE, 1'b0, 2'b10, 1'b0, 32'h0,        32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 5, 4, 32'hCAFEBABE};
        vecs[13] = '{32'h1A2,      1'b0, 2'b01, 1'b0, 32'h0,        32'h00007FFF, 32'h00007FFF, 1'b0, 2, 1, 32'h00007FFF};
        vecs[14] = '{32'h202,      1'b0, 2'b10, 1'b1, 32'h0,        32'h80000001, 32'h80000001, 1'b0, 5, 4, 32'h80000001};
        vecs[15] = '{32'h300,      1'b1, 2'b11, 1'b0, 32'h55555555, 32'h11111111, 32'h0,        1'b1, 1, 0, 32'h11111111};

        // Reset with a request pending: nothing may be accepted or emitted.
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_wr = 1'b0;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", req_ready, 1'b0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
        check("reset_mem", {mem_en, mem_wr, mem_addr, mem_length, mem_sign, mem_wdata}, 68'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1'b1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Held req_valid: accepts land every third cycle, one response between each.
        poke32(32'h10, 32'h12345678);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_wr = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        rsp_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (req_ready) accepts.push_back(k);
            if (rsp_valid) begin
                rsp_cnt++;
                check($sformatf("b2b_rdata_k%0d", k), rsp_rdata, 32'h12345678);
            end
            if (k < 6) @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("b2b_accept_count", accepts.size(), 3);
        if (accepts.size() == 3) begin
            check("b2b_gap1", accepts[1] - accepts[0], 3);
            check("b2b_gap2", accepts[2] - accepts[1], 3);
        end
        check("b2b_rsp_count", rsp_cnt, 2);
        for (int n = 0; n < 10 && !req_ready; n++) @(negedge clk);
        @(negedge clk);
        check("b2b_drained", req_ready, 1'b1);

        // Reset during the second split cycle of a wrapping word load.
        @(negedge clk);
        acc_log.delete();
        req_valid = 1'b1; req_addr = 32'hFFFFFFFE; req_wr = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifndef LSU_MISALIGN_TRAP_EN
        check("rst_mid_addr2", {mem_en, mem_addr}, {1'b1, 32'hFFFFFFFF});
`endif
        rst_n = 1'b0;
        mon_on = 1'b0;
        @(negedge clk);
        check("rst_mid_quiet", {rsp_valid, mem_en, req_ready}, 3'b000);
        rst_n = 1'b1;
        mon_on = 1'b1;
        rsp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check("rst_mid_no_rsp", rsp_cnt, 0);
        check("rst_mid_ready", req_ready, 1'b1);
`ifndef LSU_MISALIGN_TRAP_EN
        check("rst_mid_naccess", acc_log.size(), 2);
`else
        check("rst_mid_naccess", acc_log.size(), 0);
`endif

        check("mem_idle_zero", idle_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
